// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants used by
// decode/control and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic opcode_supported(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE) ||
           (opc == OPC_BRANCH) || (opc == OPC_RTYPE);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the imem req/ack bus, the decode valid/ready path and the branch
// redirect inputs seen by the fetch stage.
interface instr_fetch_if #(parameter int ADDR_W = 32);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              instr_illegal;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc, instr_illegal,
    input  instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc, instr_illegal,
    output instr_ready, branch_taken, branch_target
  );

endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter with asynchronous reset, load (redirect) and +4 increment.
// pc_next exposes the value the register takes on the coming edge.
module instr_fetch_pc_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_reg;

  // Load has priority; the increment wraps modulo 2^ADDR_W.
  always_comb begin
    pc_next = pc_reg;
    if (load) begin
      pc_next = load_pc;
    end else if (inc) begin
      pc_next = pc_reg + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches words over imem req/ack and hands them
// to decode via valid/ready. Define ILLEGAL_FLAG_EN to enable the opcode flag.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_e      state_reg, state_next;
  logic              kill_reg, kill_next;
  logic              valid_reg, valid_next;
  logic [31:0]       instr_reg, instr_next;
  logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] target_aligned;

  assign target_aligned = {bus.branch_target[ADDR_W-1:2], 2'b00};

  instr_fetch_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (bus.branch_taken),
    .load_pc(target_aligned),
    .inc    (pc_inc),
    .pc     (pc),
    .pc_next(pc_next)
  );

  always_comb begin
    state_next    = state_reg;
    kill_next     = kill_reg;
    valid_next    = valid_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    pc_inc        = 1'b0;
    case (state_reg)
      FETCH_IDLE: begin
        state_next = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (bus.imem_ack) begin
          if (kill_reg || bus.branch_taken) begin
            // Word belongs to a squashed path; refetch from the updated pc.
            kill_next = 1'b0;
          end else begin
            instr_next    = bus.imem_rdata;
            instr_pc_next = pc;
            valid_next    = 1'b1;
            pc_inc        = 1'b1;
            state_next    = FETCH_HOLD;
          end
        end else if (bus.branch_taken) begin
          // The outstanding request cannot be withdrawn, so mark its word dead.
          kill_next = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (bus.branch_taken || bus.instr_ready) begin
          valid_next = 1'b0;
          state_next = FETCH_REQ;
        end
      end
      default: begin
        state_next = FETCH_IDLE;
        kill_next  = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  // Address freezes while a request waits for its ack, otherwise tracks the pc.
  assign addr_next = (state_reg == FETCH_REQ && !bus.imem_ack) ? addr_reg : pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH_IDLE;
      kill_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      addr_reg     <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      kill_reg     <= kill_next;
      valid_reg    <= valid_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      addr_reg     <= addr_next;
    end
  end

  assign bus.imem_req    = (state_reg == FETCH_REQ);
  assign bus.imem_addr   = addr_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;

`ifdef ILLEGAL_FLAG_EN
  logic illegal_reg;
  logic capture;

  assign capture = (state_reg == FETCH_REQ) && bus.imem_ack &&
                   !kill_reg && !bus.branch_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_reg <= 1'b0;
    end else if (capture) begin
      illegal_reg <= !opcode_supported(bus.imem_rdata[6:0]);
    end
  end

  assign bus.instr_illegal = illegal_reg;
`else
  assign bus.instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed stimulus queues expected fetch
// addresses and delivered instructions; a negedge monitor pops and compares.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(
    .ADDR_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef ILLEGAL_FLAG_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  int checks   = 0;
  int failures = 0;

  // imem model state
  logic        model_ack   = 1'b0;
  logic [31:0] model_rdata = '0;
  logic        spurious_ack = 1'b0;
  int          acks_left = 0;
  int          lat       = 1;
  int          cnt       = 0;

  assign bus.imem_ack   = model_ack | spurious_ack;
  assign bus.imem_rdata = spurious_ack ? 32'hFFFF_FFFF : model_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0011_2023;
      32'h0000_0004: return 32'h0020_8663;
      32'h0000_0008: return 32'h0040_A183;
      32'h0000_000C: return 32'h0051_2003;
      32'h0000_0010: return 32'h0020_8033;
      32'h0000_0100: return 32'h0011_2023;
      32'h0000_0104: return 32'h0020_8663;
      32'h0000_0200: return 32'hFFFF_FFFF;
      32'h0000_0204: return 32'h41FF_8FB3;
      32'hFFFF_FFFC: return 32'h0000_0013;
      default:       return 32'h0BAD_0BAD;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_instr(input logic [31:0] pc, input logic [31:0] w, input logic ill);
    exp_t e;
    e.pc   = pc;
    e.word = w;
    e.ill  = ill & ILL_EN;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.instr_valid) begin
      failures++;
      $display("FAIL %s timeout instr_valid=0 required=1", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((addr_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(addr_q.size() + exp_q.size()), 32'd0);
    addr_q.delete();
    exp_q.delete();
  endtask

  // imem responder: acks lat+1 cycles after req is seen, while acks remain
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (model_ack) begin
        model_ack = 1'b0;
        cnt = 0;
      end else if (bus.imem_req && acks_left > 0) begin
        cnt++;
        if (cnt > lat) begin
          model_ack   = 1'b1;
          model_rdata = mem_word(bus.imem_addr);
          acks_left--;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor / scoreboard
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    logic [31:0] ea;
    exp_t        ee;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.imem_req && bus.imem_ack) begin
          $display("fetch addr=%h rdata=%h", bus.imem_addr, bus.imem_rdata);
          if (addr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fetch_unexpected got addr=%h required none", bus.imem_addr);
          end else begin
            ea = addr_q.pop_front();
            chk("fetch_addr", bus.imem_addr, ea);
          end
        end
        // a redirect in HOLD squashes the word even if ready is high
        if (bus.instr_valid && bus.instr_ready && !bus.branch_taken) begin
          $display("instr pc=%h word=%h illegal=%b", bus.instr_pc, bus.instr, bus.instr_illegal);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL instr_unexpected got pc=%h required none", bus.instr_pc);
          end else begin
            ee = exp_q.pop_front();
            chk("instr_pc", bus.instr_pc, ee.pc);
            chk("instr_word", bus.instr, ee.word);
            chk("instr_illegal", {31'd0, bus.instr_illegal}, {31'd0, ee.ill});
          end
        end
        if (prev_req && !prev_ack && bus.imem_req)
          chk("addr_stable", bus.imem_addr, prev_addr);
        prev_req  = bus.imem_req;
        prev_ack  = bus.imem_ack;
        prev_addr = bus.imem_addr;
      end else begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_illegal", {31'd0, bus.instr_illegal}, 32'd0);

    // 1: sequential fetch 0x0,0x4,0x8 with ready=1
    tick();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    acks_left = 3;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    push_instr(32'h0, 32'h0011_2023, 1'b0);
    push_instr(32'h4, 32'h0020_8663, 1'b0);
    push_instr(32'h8, 32'h0040_A183, 1'b0);
    @(negedge clk);
    chk("t1_bubble_req", {31'd0, bus.imem_req}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        chk("t1_req_clk1", {31'd0, bus.imem_req}, 32'd1);
        chk("t1_addr_clk1", bus.imem_addr, 32'h0);
      end
      chk("t1_valid_clk", {31'd0, bus.instr_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    wait_drain("t1_drain");

    // 2: decode stalls 5 cycles, word held, no new request
    tick();
    bus.instr_ready = 1'b0;
    acks_left = 1;
    addr_q.push_back(32'hC);
    push_instr(32'hC, 32'h0051_2003, 1'b0);
    wait_valid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("t2_hold_instr", bus.instr, 32'h0051_2003);
      chk("t2_hold_pc", bus.instr_pc, 32'hC);
      chk("t2_hold_noreq", {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk);
    end
    tick();
    bus.instr_ready = 1'b1;
    wait_drain("t2_drain");

    // 3: redirect to 0x103 while REQ waits, ack 2 cycles later is dropped
    tick();
    bus.instr_ready   = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h103;
    acks_left = 2;
    addr_q.push_back(32'h10);
    addr_q.push_back(32'h100);
    push_instr(32'h100, 32'h0011_2023, 1'b0);
    tick();
    bus.branch_taken = 1'b0;
    wait_drain("t3_drain");

    // 4: redirect in HOLD with ready=1 the same cycle
    tick();
    bus.instr_ready = 1'b0;
    acks_left = 1;
    addr_q.push_back(32'h104);
    wait_valid("t4_valid");
    tick();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h200;
    bus.instr_ready   = 1'b1;
    tick();
    bus.branch_taken = 1'b0;
    acks_left = 2;
    addr_q.push_back(32'h200);
    addr_q.push_back(32'h204);
    push_instr(32'h200, 32'hFFFF_FFFF, 1'b1);
    push_instr(32'h204, 32'h41FF_8FB3, 1'b0);
    @(negedge clk);
    chk("t4_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    chk("t4_addr_target", bus.imem_addr, 32'h200);
    wait_drain("t4_drain");

    // 5: redirect coinciding with ack, then PC wrap 0xFFFFFFFC -> 0x0
    tick();
    acks_left = 1;
    addr_q.push_back(32'h208);
    tick();
    tick();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    bus.branch_taken = 1'b0;
    acks_left = 2;
    addr_q.push_back(32'hFFFF_FFFC);
    addr_q.push_back(32'h0);
    push_instr(32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
    push_instr(32'h0, 32'h0011_2023, 1'b0);
    @(negedge clk);
    chk("t5_addr_redirect", bus.imem_addr, 32'hFFFF_FFFC);
    chk("t5_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    wait_drain("t5_drain");

    // 6: async reset mid-REQ, late ack ignored, restart at RESET_PC
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t6_async_addr", bus.imem_addr, 32'h0);
    chk("t6_async_instr", bus.instr, 32'h0);
    chk("t6_async_pc", bus.instr_pc, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    spurious_ack = 1'b1;
    acks_left = 2;
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    push_instr(32'h0, 32'h0011_2023, 1'b0);
    push_instr(32'h4, 32'h0020_8663, 1'b0);
    @(posedge clk);
    #1;
    spurious_ack = 1'b0;
    @(negedge clk);
    chk("t6_restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t6_restart_addr", bus.imem_addr, 32'h0);
    chk("t6_restart_valid", {31'd0, bus.instr_valid}, 32'd0);
    wait_drain("t6_drain");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
